key_mode_ctrl: RTL and testbench

KEY_MODE_CTRL -- requirements
Module: key_mode_ctrl

---
 rtl/key_mode_ctrl.sv | 155 +++++++++++++++
 tb/tb_key_mode_ctrl.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/key_mode_ctrl.sv
// key_mode_ctrl: two-key (NEXT/PREV) mode selector with debounce, short/long
// press detection and an external mode-set handshake.
//   sys_clk_i, sys_rst_n_i      : clock, async active-low reset
//   key_button_i[1:0]           : raw active-low keys, [1]=NEXT [0]=PREV
//   mode_set_valid_i/idx_i      : external set request (accepted when ready)
//   mode_set_ready_o            : high while the mode FSM is in RUN
//   mode_idx_o / mode_onehot_o  : current mode, binary and one-hot
//   led_indicate_o              : active-low LEDs (~mode_onehot_o)
//   mode_change_o / set_err_o   : single-cycle status pulses

// Per-key path: 2-flop sync, debouncer, press FSM emitting short/long pulses.
module key_press #(
  parameter logic [19:0] DEBOUNCE_CYCLES   = 20'd1_000_000,
  parameter logic [31:0] LONG_PRESS_CYCLES = 32'd50_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_raw,
  output logic short_evt,
  output logic long_evt
);
  typedef enum logic [1:0] {K_UP, K_DOWN, K_LONG} kst_t;

  logic        s1, s2, deb;
  logic [19:0] dcnt;
  logic [31:0] hold;
  kst_t        st;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b1; s2 <= 1'b1; deb <= 1'b1; dcnt <= '0;
      st <= K_UP; hold <= '0; short_evt <= 1'b0; long_evt <= 1'b0;
    end else begin
      s1 <= key_raw;
      s2 <= s1;
      // A sample equal to the accepted level means the synced level moved
      // back, so the run of differing samples restarts.
      if (s2 == deb)                         dcnt <= '0;
      else if (dcnt == DEBOUNCE_CYCLES - 20'd1) begin deb <= s2; dcnt <= '0; end
      else                                   dcnt <= dcnt + 20'd1;

      short_evt <= 1'b0;
      long_evt  <= 1'b0;
      case (st)
        K_UP: begin
          hold <= '0;
          if (!deb) st <= K_DOWN;
        end
        K_DOWN: begin
          if (deb) begin
            st <= K_UP; short_evt <= 1'b1; hold <= '0;
          end else begin
            if (hold != LONG_PRESS_CYCLES) hold <= hold + 32'd1;
            if (hold == LONG_PRESS_CYCLES - 32'd1) begin
              st <= K_LONG; long_evt <= 1'b1;
            end
          end
        end
        K_LONG:  if (deb) st <= K_UP;   // release after long: silent
        default: st <= K_UP;
      endcase
    end
  end
endmodule

module key_mode_ctrl #(
  parameter int          MODE_NUM          = 4,
  parameter logic [19:0] DEBOUNCE_CYCLES   = 20'd1_000_000,
  parameter logic [31:0] LONG_PRESS_CYCLES = 32'd50_000_000,
  localparam int         MW = (MODE_NUM > 2) ? $clog2(MODE_NUM) : 1
) (
  input  logic                sys_clk_i,
  input  logic                sys_rst_n_i,
  input  logic [1:0]          key_button_i,
  input  logic                mode_set_valid_i,
  input  logic [MW-1:0]       mode_set_idx_i,
  output logic                mode_set_ready_o,
  output logic [MW-1:0]       mode_idx_o,
  output logic [MODE_NUM-1:0] mode_onehot_o,
  output logic [MODE_NUM-1:0] led_indicate_o,
  output logic                mode_change_o,
  output logic                set_err_o
);
  typedef enum logic {IDLE, RUN} mst_t;

  localparam logic [MW-1:0]       LAST = MW'(MODE_NUM - 1);
  localparam logic [MW-1:0]       ONE  = MW'(1);
  localparam logic [MODE_NUM-1:0] OH1  = MODE_NUM'(1);

  logic [1:0]    short_evt, long_evt;
  logic [MW-1:0] nxt_idx;
  logic          err_nxt;
  mst_t          state;

  for (genvar k = 0; k < 2; k++) begin : g_key
    key_press #(
      .DEBOUNCE_CYCLES  (DEBOUNCE_CYCLES),
      .LONG_PRESS_CYCLES(LONG_PRESS_CYCLES)
    ) u_key (
      .clk      (sys_clk_i),
      .rst_n    (sys_rst_n_i),
      .key_raw  (key_button_i[k]),
      .short_evt(short_evt[k]),
      .long_evt (long_evt[k])
    );
  end

  // Priority: long press > accepted set > NEXT short > PREV short.
  // Both shorts together match neither single-key case and are dropped.
  always_comb begin
    nxt_idx = mode_idx_o;
    err_nxt = 1'b0;
    if (long_evt != 2'b00) begin
      nxt_idx = '0;
    end else if (mode_set_valid_i && mode_set_ready_o) begin
      if (32'(mode_set_idx_i) >= 32'(MODE_NUM)) err_nxt = 1'b1;
      else                                      nxt_idx = mode_set_idx_i;
    end else if (short_evt == 2'b10) begin
      nxt_idx = (mode_idx_o == LAST) ? '0 : mode_idx_o + ONE;
    end else if (short_evt == 2'b01) begin
      nxt_idx = (mode_idx_o == '0) ? LAST : mode_idx_o - ONE;
    end
  end

  always_ff @(posedge sys_clk_i or negedge sys_rst_n_i) begin
    if (!sys_rst_n_i) begin
      state            <= IDLE;
      mode_idx_o       <= '0;
      mode_onehot_o    <= '0;
      led_indicate_o   <= '1;
      mode_set_ready_o <= 1'b0;
      mode_change_o    <= 1'b0;
      set_err_o        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          state            <= RUN;
          mode_set_ready_o <= 1'b1;
          mode_onehot_o    <= OH1 << mode_idx_o;
          led_indicate_o   <= ~(OH1 << mode_idx_o);
          mode_change_o    <= 1'b0;
          set_err_o        <= 1'b0;
        end
        default: begin
          mode_set_ready_o <= 1'b1;
          mode_idx_o       <= nxt_idx;
          mode_onehot_o    <= OH1 << nxt_idx;
          led_indicate_o   <= ~(OH1 << nxt_idx);
          mode_change_o    <= (nxt_idx != mode_idx_o);
          set_err_o        <= err_nxt;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_key_mode_ctrl.sv
// Directed bench for key_mode_ctrl: main instance MODE_NUM=4, a second
// MODE_NUM=3 instance for out-of-range set handling. DEBOUNCE=4, LONG=20.
module tb_key_mode_ctrl;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] key, key3;
  logic       vld, vld3;
  logic [1:0] sidx, sidx3;
  logic       rdy, rdy3, chg, chg3, err, err3;
  logic [1:0] idx, idx3;
  logic [3:0] oh, led;
  logic [2:0] oh3, led3;

  int n_cmp = 0;
  int n_bad = 0;
  int chg_cnt = 0;
  int base;

  always #5 clk = ~clk;
  always @(posedge clk) if (chg === 1'b1) chg_cnt <= chg_cnt + 1;

  key_mode_ctrl #(.MODE_NUM(4), .DEBOUNCE_CYCLES(20'd4), .LONG_PRESS_CYCLES(32'd20)) dut (
    .sys_clk_i(clk), .sys_rst_n_i(rst_n), .key_button_i(key),
    .mode_set_valid_i(vld), .mode_set_idx_i(sidx), .mode_set_ready_o(rdy),
    .mode_idx_o(idx), .mode_onehot_o(oh), .led_indicate_o(led),
    .mode_change_o(chg), .set_err_o(err));

  key_mode_ctrl #(.MODE_NUM(3), .DEBOUNCE_CYCLES(20'd4), .LONG_PRESS_CYCLES(32'd20)) dut3 (
    .sys_clk_i(clk), .sys_rst_n_i(rst_n), .key_button_i(key3),
    .mode_set_valid_i(vld3), .mode_set_idx_i(sidx3), .mode_set_ready_o(rdy3),
    .mode_idx_o(idx3), .mode_onehot_o(oh3), .led_indicate_o(led3),
    .mode_change_o(chg3), .set_err_o(err3));

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Hold the keys in 'mask' low for 'hold' cycles, then release and settle.
  task automatic press(input logic [1:0] mask, input int hold);
    key = ~mask;
    cyc(hold);
    key = 2'b11;
    cyc(12);
  endtask

  initial begin
    rst_n = 1'b0; key = 2'b11; key3 = 2'b11;
    vld = 1'b0; sidx = '0; vld3 = 1'b0; sidx3 = '0;
    cyc(3);
    chk("rst_idx", 32'(idx), 32'd0);
    chk("rst_oh",  32'(oh),  32'h0);
    chk("rst_led", 32'(led), 32'hF);
    chk("rst_rdy", 32'(rdy), 32'd0);

    // Release: one cycle in IDLE, then RUN at mode 0.
    rst_n = 1'b1;
    #1;
    chk("idle_oh",  32'(oh),  32'h0);
    chk("idle_rdy", 32'(rdy), 32'd0);
    cyc(1);
    chk("run_idx", 32'(idx), 32'd0);
    chk("run_oh",  32'(oh),  32'h1);
    chk("run_led", 32'(led), 32'hE);
    chk("run_rdy", 32'(rdy), 32'd1);
    cyc(2);

    // Four NEXT shorts, each preceded by a 3-cycle glitch.
    base = chg_cnt;
    for (int i = 1; i <= 4; i++) begin
      key = 2'b01; cyc(3); key = 2'b11; cyc(10);
      chk("glitch_idx", 32'(idx), 32'((i - 1) % 4));
      chk("glitch_chg", 32'(chg_cnt - base), 32'(i - 1));
      press(2'b10, 8);
      chk("next_idx", 32'(idx), 32'(i % 4));
    end
    chk("next_pulses", 32'(chg_cnt - base), 32'd4);
    chk("next_oh",  32'(oh),  32'h1);

    // PREV wrap 0 -> 3, then PREV 3 -> 2.
    press(2'b01, 8);
    chk("prev_wrap", 32'(idx), 32'd3);
    chk("prev_led",  32'(led), 32'h7);
    press(2'b01, 8);
    chk("prev_dec", 32'(idx), 32'd2);

    // NEXT long press at index 2: long pulse at press edge 27, index at 28.
    key = 2'b01;
    cyc(27);
    chk("long_pre", 32'(idx), 32'd2);
    cyc(1);
    chk("long_idx", 32'(idx), 32'd0);
    chk("long_chg", 32'(chg), 32'd1);
    cyc(2);
    base = chg_cnt;
    key = 2'b11;
    cyc(12);
    chk("long_rel_idx", 32'(idx), 32'd0);
    chk("long_rel_chg", 32'(chg_cnt - base), 32'd0);

    // Both keys short, released together: ignored.
    base = chg_cnt;
    press(2'b11, 8);
    chk("both_idx", 32'(idx), 32'd0);
    chk("both_chg", 32'(chg_cnt - base), 32'd0);

    // External set to 2, then the same index again.
    vld = 1'b1; sidx = 2'd2;
    cyc(1);
    chk("set_idx", 32'(idx), 32'd2);
    chk("set_chg", 32'(chg), 32'd1);
    chk("set_oh",  32'(oh),  32'h4);
    cyc(1);
    chk("set_same_idx", 32'(idx), 32'd2);
    chk("set_same_chg", 32'(chg), 32'd0);
    vld = 1'b0;
    cyc(2);

    // Set to 1 in the same cycle as a NEXT long event: long wins.
    key = 2'b01;
    cyc(27);
    vld = 1'b1; sidx = 2'd1;
    cyc(1);
    vld = 1'b0;
    chk("set_long_idx", 32'(idx), 32'd0);
    key = 2'b11;
    cyc(12);
    chk("set_long_hold", 32'(idx), 32'd0);

    // MODE_NUM=3: index 3 is out of range.
    vld3 = 1'b1; sidx3 = 2'd3;
    cyc(1);
    vld3 = 1'b0;
    chk("err_pulse", 32'(err3), 32'd1);
    chk("err_idx",   32'(idx3), 32'd0);
    chk("err_chg",   32'(chg3), 32'd0);
    cyc(1);
    chk("err_one",   32'(err3), 32'd0);
    vld3 = 1'b1; sidx3 = 2'd2;
    cyc(1);
    vld3 = 1'b0;
    chk("m3_top_idx", 32'(idx3), 32'd2);
    chk("m3_top_oh",  32'(oh3),  32'h4);
    chk("m3_top_err", 32'(err3), 32'd0);

    // Reset mid-hold at index 3; key held across reset becomes a new press.
    vld = 1'b1; sidx = 2'd3;
    cyc(1);
    vld = 1'b0;
    chk("pre_rst_idx", 32'(idx), 32'd3);
    key = 2'b10;
    cyc(15);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_idx", 32'(idx), 32'd0);
    chk("arst_oh",  32'(oh),  32'h0);
    chk("arst_led", 32'(led), 32'hF);
    chk("arst_rdy", 32'(rdy), 32'd0);
    chk("arst_chg", 32'(chg), 32'd0);
    chk("arst_idx3", 32'(idx3), 32'd0);
    cyc(2);
    rst_n = 1'b1;
    cyc(10);
    chk("post_rst_rdy", 32'(rdy), 32'd1);
    chk("post_rst_idx", 32'(idx), 32'd0);
    key = 2'b11;
    cyc(12);
    chk("fresh_press", 32'(idx), 32'd3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
